// File: rtl/ws2812_pattern_engine_if.sv
// Avalon-MM slave register bus of the WS2812 pattern engine.
interface ws2812_pattern_engine_if;
    logic [2:0]  s_address;
    logic        s_write_en;
    logic [31:0] s_write_data;
    logic        s_read_en;
    logic [31:0] s_read_data;

    modport master (
        output s_address,
        output s_write_en,
        output s_write_data,
        output s_read_en,
        input  s_read_data
    );

    modport slave (
        input  s_address,
        input  s_write_en,
        input  s_write_data,
        input  s_read_en,
        output s_read_data
    );
endinterface

// File: rtl/ws2812_pattern_engine.sv
// Autonomous WS2812 frame generator: fills the driver colour RAM one pixel
// per clock, requests a transmit, waits for it, idles a programmable gap,
// advances the animation phase and repeats.
module ws2812_pattern_engine #(
    parameter int LED_NUM  = 32,
    parameter int ADDR_BIT = $clog2(LED_NUM)
) (
    input  logic                   s_clk,
    input  logic                   s_reset_n,
    ws2812_pattern_engine_if.slave bus,
    output logic [ADDR_BIT-1:0]    led_wraddress,
    output logic [31:0]            led_wrdata,
    output logic                   led_wren,
    output logic                   led_update_request,
    input  logic                   led_update_done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        REQ,
        WAIT_DONE,
        GAP
    } state_t;

    localparam logic [ADDR_BIT-1:0] LAST_IDX  = ADDR_BIT'(LED_NUM - 1);
    localparam logic [ADDR_BIT:0]   LED_COUNT = (ADDR_BIT + 1)'(LED_NUM);

    // Register file
    logic        ctrl_enable;
    logic [1:0]  ctrl_mode;
    logic [23:0] color;
    logic [31:0] period;
    logic [23:0] step;

    // Per-frame snapshot and animation state
    logic [1:0]          snap_mode;
    logic [23:0]         snap_color;
    logic [23:0]         snap_step;
    logic [ADDR_BIT-1:0] idx;
    logic [ADDR_BIT-1:0] phase;
    logic [23:0]         frame_base;
    logic [23:0]         accum;
    logic [31:0]         gap_cnt;
    logic [15:0]         frame_count;

    state_t state_q;
    state_t state_d;

    logic                busy;
    logic                gap_done;
    logic [ADDR_BIT:0]   phase_inc;
    logic [ADDR_BIT-1:0] phase_next;
    logic [23:0]         frame_base_next;
    logic [31:0]         period_eff;
    logic [23:0]         pixel;
    logic [31:0]         rd_mux;

    assign busy            = (state_q != IDLE);
    assign gap_done        = (gap_cnt <= 32'd1);
    assign phase_inc       = {1'b0, phase} + 1'b1;
    assign phase_next      = (phase_inc == LED_COUNT) ? '0 : phase_inc[ADDR_BIT-1:0];
    assign frame_base_next = frame_base + snap_step;
    assign period_eff      = (period == 32'd0) ? 32'd1 : period;

    // Register writes from the Avalon bus
    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            ctrl_enable <= 1'b0;
            ctrl_mode   <= '0;
            color       <= '0;
            period      <= '0;
            step        <= '0;
        end else if (bus.s_write_en) begin
            case (bus.s_address)
                3'd0: begin
                    ctrl_enable <= bus.s_write_data[0];
                    ctrl_mode   <= bus.s_write_data[2:1];
                end
                3'd1:    color  <= bus.s_write_data[23:0];
                3'd2:    period <= bus.s_write_data;
                3'd4:    step   <= bus.s_write_data[23:0];
                default: ;
            endcase
        end
    end

    // Read-back multiplexer
    always_comb begin
        rd_mux = '0;
        case (bus.s_address)
            3'd0: rd_mux[2:0] = {ctrl_mode, ctrl_enable};
            3'd1: rd_mux[23:0] = color;
            3'd2: rd_mux = period;
            3'd3: begin
                rd_mux[31:16] = frame_count;
                rd_mux[0]     = busy;
            end
            3'd4: rd_mux[23:0] = step;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, held while no read is strobed
    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            bus.s_read_data <= '0;
        end else if (bus.s_read_en) begin
            bus.s_read_data <= rd_mux;
        end
    end

    // FSM state register
    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pixel colour for the current fill index
    always_comb begin
        pixel = snap_color;
        case (snap_mode)
            2'd1:    pixel = (idx == phase) ? snap_color : '0;
            2'd2:    pixel = accum;
            default: pixel = snap_color;
        endcase
    end

    // Next-state logic and RAM / driver outputs
    always_comb begin
        state_d            = state_q;
        led_wren           = 1'b0;
        led_wraddress      = '0;
        led_wrdata         = '0;
        led_update_request = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_enable) state_d = FILL;
            end
            FILL: begin
                led_wren      = 1'b1;
                led_wraddress = idx;
                led_wrdata    = {8'h00, pixel};
                if (idx == LAST_IDX) state_d = REQ;
            end
            REQ: begin
                led_update_request = 1'b1;
                if (!led_update_done) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (led_update_done) state_d = GAP;
            end
            GAP: begin
                if (gap_done) state_d = ctrl_enable ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: snapshot, fill index, gradient accumulator, gap and phase
    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            snap_mode   <= '0;
            snap_color  <= '0;
            snap_step   <= '0;
            idx         <= '0;
            phase       <= '0;
            frame_base  <= '0;
            accum       <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_enable) begin
                        idx        <= '0;
                        snap_mode  <= ctrl_mode;
                        snap_color <= color;
                        snap_step  <= step;
                        phase      <= '0;
                        frame_base <= color;
                        accum      <= color;
                    end
                end
                FILL: begin
                    idx   <= idx + 1'b1;
                    accum <= accum + snap_step;
                end
                WAIT_DONE: begin
                    if (led_update_done) gap_cnt <= period_eff;
                end
                GAP: begin
                    if (gap_done) begin
                        phase       <= phase_next;
                        frame_base  <= frame_base_next;
                        frame_count <= frame_count + 16'd1;
                        // Re-entering FILL straight from GAP: the accumulator must
                        // start from the advanced base, not the stale register.
                        if (ctrl_enable) begin
                            idx        <= '0;
                            snap_mode  <= ctrl_mode;
                            snap_color <= color;
                            snap_step  <= step;
                            accum      <= frame_base_next;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
